// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default geometry and FSM state encoding.
package if_prefetch_unit_pkg;

    localparam int IF_PC_W      = 32;
    localparam int IF_INSTR_W   = 32;
    localparam int IF_MEM_WORDS = 64;
    localparam int IF_Q_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } if_state_e;

    function automatic int word_bytes(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Loader, control and IF/ID handshake signals of the fetch stage.
// Performance counter outputs exist only when IF_PERF_CNT_EN is defined.
interface if_prefetch_unit_if #(
    parameter int PC_W    = if_prefetch_unit_pkg::IF_PC_W,
    parameter int INSTR_W = if_prefetch_unit_pkg::IF_INSTR_W
);
    logic               i_wr_en;
    logic [INSTR_W-1:0] i_wr_data;
    logic               i_clear;
    logic               i_start;
    logic               i_halt;
    logic               i_redirect;
    logic [PC_W-1:0]    i_redirect_pc;
    logic               i_ready;
    logic               o_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_pc;
    logic [PC_W-1:0]    o_next_seq_pc;
    logic               o_mem_full;
    logic               o_mem_empty;
    logic [1:0]         o_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0]        o_fetch_cnt;
    logic [31:0]        o_stall_cnt;
`endif

    modport master (
        output i_wr_en, i_wr_data, i_clear, i_start, i_halt, i_redirect, i_redirect_pc, i_ready,
`ifdef IF_PERF_CNT_EN
        input  o_fetch_cnt, o_stall_cnt,
`endif
        input  o_valid, o_instr, o_pc, o_next_seq_pc, o_mem_full, o_mem_empty, o_state
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_clear, i_start, i_halt, i_redirect, i_redirect_pc, i_ready,
`ifdef IF_PERF_CNT_EN
        output o_fetch_cnt, o_stall_cnt,
`endif
        output o_valid, o_instr, o_pc, o_next_seq_pc, o_mem_full, o_mem_empty, o_state
    );

endinterface

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// Prefetch queue holding {pc, instr} entries; flush wins over push and pop.
module if_prefetch_unit_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [W-1:0]     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    logic [W-1:0]     slot_q [DEPTH];
    logic [W-1:0]     slot_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                slot_d[wr_ptr_q] = i_push_data;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (i_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = slot_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: program loader, synchronous instruction memory and prefetch queue.
// Defining IF_PERF_CNT_EN adds fetch and stall counters.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int PC_W      = IF_PC_W,
    parameter int INSTR_W   = IF_INSTR_W,
    parameter int MEM_WORDS = IF_MEM_WORDS,
    parameter int Q_DEPTH   = IF_Q_DEPTH
) (
    input logic               i_clk,
    input logic               i_reset,
    if_prefetch_unit_if.slave bus
);

    localparam int WORD_BYTES = word_bytes(INSTR_W);
    localparam int OFF        = $clog2(WORD_BYTES);
    localparam int AW         = $clog2(MEM_WORDS);
    localparam int CNT_W      = $clog2(Q_DEPTH) + 1;
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(WORD_BYTES);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(WORD_BYTES - 1);

    if_state_e          state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic               epoch_q, epoch_d;
    logic               inflight_q, inflight_d;
    logic               inflight_epoch_q, inflight_epoch_d;
    logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
    logic [INSTR_W-1:0] rd_data_q, rd_data_d;
    logic [INSTR_W-1:0] mem_q [MEM_WORDS];

    logic [AW-1:0]             rd_idx;
    logic                      redirect_act, flush, issue, push, pop, mem_we;
    logic                      q_empty;
    logic [CNT_W-1:0]          q_count;
    logic [PC_W+INSTR_W-1:0]   head;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= ST_LOAD;
        else          state_q <= state_d;
    end

    // Redirect outranks halt, so a RUN-state redirect keeps the stage running.
    always_comb begin
        state_d = state_q;
        if (bus.i_clear) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (bus.i_start) state_d = ST_RUN;
                ST_RUN:  if (!bus.i_redirect && bus.i_halt) state_d = ST_HALT;
                default: state_d = state_q;
            endcase
        end
    end

    // Issue is bounded by queue occupancy plus the read already in flight.
    always_comb begin
        rd_idx       = fetch_pc_q[OFF +: AW];
        redirect_act = bus.i_redirect && (state_q != ST_LOAD) && !bus.i_clear;
        flush        = bus.i_clear || redirect_act;
        issue        = (state_q == ST_RUN) && !flush && !bus.i_halt &&
                       (({1'b0, q_count} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(Q_DEPTH));
        pop          = !q_empty && bus.i_ready && !flush;
        push         = inflight_q && (inflight_epoch_q == epoch_q) && !flush;
        mem_we       = (state_q == ST_LOAD) && bus.i_wr_en && !bus.i_clear &&
                       (wr_ptr_q < (AW + 1)'(MEM_WORDS));

        fetch_pc_d       = fetch_pc_q;
        wr_ptr_d         = wr_ptr_q;
        epoch_d          = epoch_q;
        inflight_d       = issue;
        inflight_epoch_d = epoch_q;
        rd_pc_d          = fetch_pc_q;
        rd_data_d        = ({1'b0, rd_idx} < wr_ptr_q) ? mem_q[rd_idx] : '0;
        if (bus.i_clear) begin
            fetch_pc_d = '0;
            wr_ptr_d   = '0;
        end else if (redirect_act) begin
            fetch_pc_d = bus.i_redirect_pc & ALIGN_MASK;
            epoch_d    = !epoch_q;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (mem_we) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc_q       <= '0;
            wr_ptr_q         <= '0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            rd_pc_q          <= '0;
            rd_data_q        <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            wr_ptr_q         <= wr_ptr_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            rd_pc_q          <= rd_pc_d;
            rd_data_q        <= rd_data_d;
        end
    end

    // Words at or above the loader pointer read as zero, so the array needs no reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= bus.i_wr_data;
    end

    if_prefetch_unit_fetch_fifo #(
        .DEPTH (Q_DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (push),
        .i_push_data ({rd_pc_q, rd_data_q}),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_head      (head),
        .o_count     (q_count),
        .o_empty     (q_empty)
    );

    assign bus.o_valid       = !q_empty;
    assign bus.o_pc          = q_empty ? '0 : head[PC_W+INSTR_W-1:INSTR_W];
    assign bus.o_instr       = q_empty ? '0 : head[INSTR_W-1:0];
    assign bus.o_next_seq_pc = bus.o_pc + PC_STEP;
    assign bus.o_mem_full    = (wr_ptr_q == (AW + 1)'(MEM_WORDS));
    assign bus.o_mem_empty   = (wr_ptr_q == '0);
    assign bus.o_state       = state_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        stall_cnt_d = stall_cnt_q + 32'(!q_empty && !bus.i_ready);
        if (bus.i_clear) begin
            fetch_cnt_d = '0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.o_fetch_cnt = fetch_cnt_q;
    assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule
